// File: rtl/pool1d_window_buffer.sv
// ---------------------------------------------------------------------------
// pool1d_window_buffer
//
// Streaming sliding-window generator for the 1-D pooling cores. Elements
// arrive one per beat along dimension 0. Each row is framed by PADDING zeros
// on both sides. One KERNEL_SIZE-wide window is emitted for every STRIDE-th
// position of that padded row. The downstream pooling core reduces each
// window combinationally.
//
// Ports
//   clk              : single clock
//   rst              : asynchronous, active-high reset
//   data_in_0        : input element (signed fixed point, passed through untouched)
//   data_in_0_valid  : input element valid
//   data_in_0_ready  : element accepted this cycle (FILL state and output slot free)
//   data_out_0       : window, index 0 holds the oldest element
//   data_out_0_valid : window valid (registered output slot)
//   data_out_0_ready : downstream accepts the window
//
// State table
//   state | meaning
//   PAD_L | injecting left-edge zeros (p < PADDING)
//   FILL  | consuming real input (p < PADDING + IN_LEN)
//   PAD_R | injecting right-edge zeros until p = PLEN-1
// ---------------------------------------------------------------------------
module pool1d_window_buffer #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int PADDING                     = 0,
    parameter int KERNEL_SIZE                 = 2,
    parameter int STRIDE                      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);

    localparam int W      = DATA_IN_0_PRECISION_0;
    localparam int K      = KERNEL_SIZE;
    localparam int IN_LEN = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int PLEN   = IN_LEN + 2 * PADDING;
    localparam int PW     = $clog2(PLEN + 1);
    localparam int FW     = $clog2(K + 1);
    localparam int SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [PW-1:0] P_PAD_L_LAST = PW'(PADDING - 1);
    localparam logic [PW-1:0] P_FILL_LAST  = PW'(PADDING + IN_LEN - 1);
    localparam logic [PW-1:0] P_LAST       = PW'(PLEN - 1);
    localparam logic [FW-1:0] FILL_FULL    = FW'(K);
    localparam logic [FW-1:0] FILL_PRE     = FW'(K - 1);
    localparam logic [SW-1:0] PHASE_LAST   = SW'(STRIDE - 1);

    if (KERNEL_SIZE < 1 || STRIDE < 1 || KERNEL_SIZE > PLEN) begin : g_bad_geometry
        $error("pool1d_window_buffer: need 1 <= KERNEL_SIZE <= padded row length and STRIDE >= 1");
    end
    if (DATA_IN_0_PRECISION_1 < 0 || DATA_IN_0_PRECISION_1 > W ||
        DATA_IN_0_TENSOR_SIZE_DIM_1 < 1) begin : g_bad_format
        $error("pool1d_window_buffer: bad fractional width or row count");
    end

    typedef enum logic [1:0] {
        PAD_L = 2'd0,
        FILL  = 2'd1,
        PAD_R = 2'd2
    } state_t;

    localparam state_t START = (PADDING > 0) ? PAD_L : FILL;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   p;
    logic [FW-1:0]   fill;
    logic [SW-1:0]   phase;
    logic [SW-1:0]   phase_nxt;
    logic [W-1:0]    shreg     [K];
    logic [W-1:0]    shreg_nxt [K];
    logic            adv;
    logic            inject;
    logic            elem_evt;
    logic            emit;

    // The output slot is free when empty or being drained this cycle.
    assign adv      = !data_out_0_valid || data_out_0_ready;
    assign elem_evt = inject || (data_in_0_ready && data_in_0_valid);

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= START;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        if (elem_evt) begin
            case (state)
                PAD_L:   if (p == P_PAD_L_LAST) state_nxt = FILL;
                FILL:    if (p == P_FILL_LAST)  state_nxt = (PADDING > 0) ? PAD_R : FILL;
                PAD_R:   if (p == P_LAST)       state_nxt = PAD_L;
                default: state_nxt = START;
            endcase
        end
    end

    // ---- FSM: outputs ----
    // Ready is masked by rst so it reads low while reset is held, even in FILL.
    always_comb begin
        data_in_0_ready = 1'b0;
        inject          = 1'b0;
        case (state)
            FILL:         data_in_0_ready = adv && !rst;
            PAD_L, PAD_R: inject          = adv && !rst;
            default:      ;
        endcase
    end

    // Window as it will look after this event; the newest element enters at K-1.
    always_comb begin
        for (int i = 0; i < K - 1; i++) shreg_nxt[i] = shreg[i + 1];
        shreg_nxt[K-1] = inject ? '0 : data_in_0;
    end

    // The first full window always emits; after that every STRIDE-th event.
    // Any event past the last complete window simply never reaches the
    // emit point before the row ends and the counters clear.
    always_comb begin
        emit      = 1'b0;
        phase_nxt = phase;
        if (fill == FILL_PRE) begin
            emit      = 1'b1;
            phase_nxt = '0;
        end else if (fill == FILL_FULL) begin
            if (phase == PHASE_LAST) begin
                emit      = 1'b1;
                phase_nxt = '0;
            end else begin
                phase_nxt = phase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p     <= '0;
            fill  <= '0;
            phase <= '0;
            shreg <= '{default: '0};
        end else if (elem_evt) begin
            shreg <= shreg_nxt;
            if (p == P_LAST) begin
                p     <= '0;
                fill  <= '0;
                phase <= '0;
            end else begin
                p     <= p + 1'b1;
                phase <= phase_nxt;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
            end
        end
    end

    // Single registered output slot; holds while valid && !ready because no
    // event (and therefore no emit) can happen then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_0_valid <= 1'b0;
            data_out_0       <= '{default: '0};
        end else if (elem_evt && emit) begin
            data_out_0_valid <= 1'b1;
            data_out_0       <= shreg_nxt;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool1d_window_buffer.sv
module tb_pool1d_window_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus; sel picks which instance the bench is talking to.
    int         sel = 0;
    logic [7:0] din = '0;
    logic       vin = 1'b0;
    logic       rout = 1'b0;

    logic       vin_a, vin_b, vin_c, vin_d;
    logic       rin_a, rin_b, rin_c, rin_d;
    logic       vout_a, vout_b, vout_c, vout_d;
    logic [7:0] dout_a [2];
    logic [7:0] dout_b [3];
    logic [7:0] dout_c [2];
    logic [7:0] dout_d [3];

    assign vin_a = vin && (sel == 0);
    assign vin_b = vin && (sel == 1);
    assign vin_c = vin && (sel == 2);
    assign vin_d = vin && (sel == 3);

    // a: IN_LEN=8 K=2 S=2 P=0
    pool1d_window_buffer #(.DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .PADDING(0), .KERNEL_SIZE(2), .STRIDE(2)) dut_a (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin_a), .data_in_0_ready(rin_a),
        .data_out_0(dout_a), .data_out_0_valid(vout_a), .data_out_0_ready(rout));
    // b: IN_LEN=4 K=3 S=2 P=1
    pool1d_window_buffer #(.DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .PADDING(1), .KERNEL_SIZE(3), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin_b), .data_in_0_ready(rin_b),
        .data_out_0(dout_b), .data_out_0_valid(vout_b), .data_out_0_ready(rout));
    // c: IN_LEN=5 K=2 S=2 P=0, two rows per frame
    pool1d_window_buffer #(.DATA_IN_0_TENSOR_SIZE_DIM_0(5), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
        .PADDING(0), .KERNEL_SIZE(2), .STRIDE(2)) dut_c (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin_c), .data_in_0_ready(rin_c),
        .data_out_0(dout_c), .data_out_0_valid(vout_c), .data_out_0_ready(rout));
    // d: IN_LEN=4 K=3 S=1 P=0
    pool1d_window_buffer #(.DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .PADDING(0), .KERNEL_SIZE(3), .STRIDE(1)) dut_d (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin_d), .data_in_0_ready(rin_d),
        .data_out_0(dout_d), .data_out_0_valid(vout_d), .data_out_0_ready(rout));

    int cfg_len [4] = '{8, 4, 5, 4};
    int cfg_k   [4] = '{2, 3, 2, 3};
    int cfg_s   [4] = '{2, 2, 2, 1};
    int cfg_pad [4] = '{0, 1, 0, 0};

    // Window packed with element j in byte j (index 0 = oldest).
    logic        cur_vout, cur_rin;
    logic [31:0] cur_pack;
    always_comb begin
        cur_vout = 1'b0;
        cur_rin  = 1'b0;
        cur_pack = '0;
        case (sel)
            0: begin cur_vout = vout_a; cur_rin = rin_a; cur_pack = {16'h0, dout_a[1], dout_a[0]}; end
            1: begin cur_vout = vout_b; cur_rin = rin_b; cur_pack = {8'h0, dout_b[2], dout_b[1], dout_b[0]}; end
            2: begin cur_vout = vout_c; cur_rin = rin_c; cur_pack = {16'h0, dout_c[1], dout_c[0]}; end
            default: begin cur_vout = vout_d; cur_rin = rin_d; cur_pack = {8'h0, dout_d[2], dout_d[1], dout_d[0]}; end
        endcase
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]  row_q [$];
    logic [7:0]  src_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          got_cyc [$];
    logic        rin_log [$];
    int          stalls, hold_viol, bp_viol;

    // Reference: pad the row, slide a K window at STRIDE, keep only full windows.
    task automatic model_row(input int c);
        int plen;
        plen = cfg_len[c] + 2 * cfg_pad[c];
        for (int st = 0; st + cfg_k[c] <= plen; st += cfg_s[c]) begin
            logic [31:0] w;
            w = '0;
            for (int j = 0; j < cfg_k[c]; j++) begin
                int idx;
                idx = st + j - cfg_pad[c];
                if (idx >= 0 && idx < cfg_len[c]) w[8*j +: 8] = row_q[idx];
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic add_row(input int c, input bit rnd, input int base);
        row_q.delete();
        for (int i = 0; i < cfg_len[c]; i++)
            row_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
        foreach (row_q[i]) src_q.push_back(row_q[i]);
        model_row(c);
    endtask

    task automatic do_reset();
        vin  = 1'b0;
        rout = 1'b0;
        rst  = 1'b1;
        src_q.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives src_q into the selected instance and collects windows into got_q.
    // Starts and ends at posedge+1. bp_len > 0 forces ready low for that many
    // cycles starting with the first cycle a window is visible.
    task automatic run(input int vin_pct, input int rdy_pct, input int bp_len, input int max_cyc);
        int          cyc;
        int          bp_left;
        bit          bp_started;
        bit          hold;
        logic [31:0] held;
        cyc = 0; bp_left = 0; bp_started = 0; hold = 0; held = '0;
        stalls = 0; hold_viol = 0; bp_viol = 0;
        rin_log.delete();
        while ((src_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < max_cyc) begin
            if (src_q.size() > 0 && $urandom_range(99) < vin_pct) begin
                vin = 1'b1; din = src_q[0];
            end else begin
                vin = 1'b0; din = 8'($urandom);
            end
            if (bp_len > 0 && !bp_started && cur_vout) begin
                bp_started = 1; bp_left = bp_len;
            end
            if (bp_left > 0) begin
                rout = 1'b0; bp_left--;
            end else begin
                rout = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            rin_log.push_back(cur_rin);
            if (vin && !cur_rin) stalls++;
            if (hold && (!cur_vout || cur_pack !== held)) hold_viol++;
            if (cur_vout && !rout) begin
                if (cur_rin) bp_viol++;
                hold = 1; held = cur_pack;
            end else begin
                hold = 0;
            end
            if (cur_vout && rout) begin
                got_q.push_back(cur_pack);
                got_cyc.push_back(cyc);
            end
            if (vin && cur_rin) void'(src_q.pop_front());
            @(posedge clk);
            #1 cyc++;
        end
        vin = 1'b0;
        checks++;
        if (cyc >= max_cyc) begin
            errors++;
            $display("FAIL run_timeout: sel=%0d after %0d cycles, %0d inputs left, %0d of %0d windows", sel, cyc, src_q.size(), got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (vout_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vout_a); end
        checks++; if (rin_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rin_a); end
        checks++; if ({dout_a[1], dout_a[0]} !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {dout_a[1], dout_a[0]}); end
        checks++; if (vout_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", vout_b); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (rin_a !== 1'b1) begin errors++; $display("FAIL post_reset_ready_nopad: got %b want 1", rin_a); end
        checks++; if (rin_b !== 1'b0) begin errors++; $display("FAIL post_reset_ready_pad: got %b want 0", rin_b); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_reset(); sel = 0;
        add_row(0, 0, 1);
        run(100, 100, 0, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            checks++; if (got_cyc[i] !== 2 * i + 2) begin errors++; $display("FAIL basic_latency[%0d]: got cycle %0d want %0d", i, got_cyc[i], 2 * i + 2); end
        end
        checks++; if (stalls !== 0) begin errors++; $display("FAIL basic_stalls: got %0d want 0", stalls); end
    endtask

    task automatic test_backpressure();
        do_reset(); sel = 0;
        add_row(0, 0, 1);
        run(100, 100, 5, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", hold_viol); end
        checks++; if (bp_viol !== 0) begin errors++; $display("FAIL bp_ready: input ready %0d times while blocked, want 0", bp_viol); end
        checks++; if (stalls !== 5) begin errors++; $display("FAIL bp_stalls: got %0d want 5", stalls); end
        if (got_cyc.size() > 0) begin
            checks++; if (got_cyc[0] !== 7) begin errors++; $display("FAIL bp_resume: first handshake cycle %0d want 7", got_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid_row();
        do_reset(); sel = 0;
        for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
        exp_q.push_back(32'h0000_0201);
        run(100, 100, 0, 50);
        rout = 1'b0;
        checks++; if (cur_vout !== 1'b1) begin errors++; $display("FAIL midrst_pending: got valid %b want 1", cur_vout); end
        rst = 1'b1;
        #1;
        checks++; if (cur_vout !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", cur_vout); end
        checks++; if (cur_pack !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", cur_pack); end
        @(negedge clk);
        checks++; if (rin_a !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", rin_a); end
        @(posedge clk);
        #1 rst = 1'b0;
        src_q.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
        add_row(0, 0, 1);
        run(100, 100, 0, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_padding();
        do_reset(); sel = 1;
        add_row(1, 0, 1);
        run(100, 100, 0, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL pad_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pad_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (rin_log.size() !== 6) begin errors++; $display("FAIL pad_cycles: got %0d want 6", rin_log.size()); end
        if (rin_log.size() >= 6) begin
            checks++; if (rin_log[0] !== 1'b0) begin errors++; $display("FAIL pad_left_ready: got %b want 0", rin_log[0]); end
            checks++; if (rin_log[5] !== 1'b0) begin errors++; $display("FAIL pad_right_ready: got %b want 0", rin_log[5]); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (cur_vout !== 1'b0) begin errors++; $display("FAIL pad_tail_emit: valid %b want 0 at idle cycle %0d", cur_vout, i); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rows();
        do_reset(); sel = 2;
        add_row(2, 0, 1);
        add_row(2, 0, 11);
        run(100, 100, 0, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rows_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rows_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (src_q.size() !== 0) begin errors++; $display("FAIL rows_consumed: %0d left want 0", src_q.size()); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (cur_vout !== 1'b0) begin errors++; $display("FAIL rows_tail_emit: valid %b want 0 at idle cycle %0d", cur_vout, i); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stride1();
        do_reset(); sel = 3;
        add_row(3, 0, 1);
        run(100, 100, 0, 100);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL s1_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL s1_window[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            checks++; if (got_cyc[i] !== i + 3) begin errors++; $display("FAIL s1_cycle[%0d]: got %0d want %0d", i, got_cyc[i], i + 3); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4; c++) begin
            do_reset(); sel = c;
            for (int r = 0; r < 3; r++) add_row(c, 1, 0);
            run(70, 60, 0, 3000);
            checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_window[%0d][%0d]: got %h want %h", c, i, got_q[i], exp_q[i]); end
            end
            checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_hold[%0d]: %0d unstable cycles, want 0", c, hold_viol); end
            checks++; if (bp_viol !== 0) begin errors++; $display("FAIL rand_ready[%0d]: ready %0d times while blocked, want 0", c, bp_viol); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_row();
        test_padding();
        test_rows();
        test_stride1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
